// File: rtl/framer_pkg.sv
// framer_pkg: shared constants, state encoding and CRC-8 byte step for the packet framer.
package framer_pkg;
  localparam int PAYLOAD_MAX_DEF = 32;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] LEN_OVERHEAD = 8'd2;
  typedef enum logic [2:0] {COLLECT, LEN, SEQ, PAYLOAD, CRC} state_t;
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC_POLY : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/framer_buf.sv
// framer_buf: payload RAM with synchronous write and combinational read.
module framer_buf #(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/packet_framer.sv
// packet_framer: buffers sensor bytes and emits LEN, SEQ, payload, CRC-8 frames over a valid/ready link.
module packet_framer
  import framer_pkg::*;
#(
  parameter int PAYLOAD_MAX = PAYLOAD_MAX_DEF
) (
  input  logic       CLK_48MHZ,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  input  logic       SEND,
  output logic [7:0] TX_BYTE,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       TX_LAST,
  output logic       BUSY
);
  localparam int AW = PAYLOAD_MAX > 1 ? $clog2(PAYLOAD_MAX) : 1;
  localparam logic [7:0] MAX = 8'(PAYLOAD_MAX);
  state_t state, state_next;
  logic [7:0] count, count_next, seq, crc, ptr, rd_data;
  logic armed, accept, xfer;
  // armed keeps DATA_READY low until the first edge after reset release
  assign DATA_READY = armed && state == COLLECT && count < MAX;
  assign accept = DATA_VALID && DATA_READY;
  assign count_next = count + 8'(accept);
  assign BUSY = state != COLLECT;
  assign TX_VALID = BUSY;
  assign TX_LAST = state == CRC;
  assign xfer = TX_VALID && TX_READY;
  assign TX_BYTE = state == LEN ? count + LEN_OVERHEAD :
                   state == SEQ ? seq :
                   state == PAYLOAD ? rd_data :
                   state == CRC ? crc : 8'h00;
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if ((SEND && count_next != 8'd0) || count_next == MAX) state_next = LEN;
      LEN:     if (xfer) state_next = SEQ;
      SEQ:     if (xfer) state_next = PAYLOAD;
      PAYLOAD: if (xfer && ptr == count - 8'd1) state_next = CRC;
      CRC:     if (xfer) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      state <= COLLECT;
      count <= 8'd0;
      seq <= 8'd0;
      crc <= 8'd0;
      ptr <= 8'd0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      count <= (xfer && TX_LAST) ? 8'd0 : count_next;
      crc <= xfer ? (TX_LAST ? 8'd0 : crc8_update(crc, TX_BYTE)) : crc;
      seq <= seq + 8'(xfer && TX_LAST);
      ptr <= state == PAYLOAD ? ptr + 8'(xfer) : 8'd0;
    end
  end
  framer_buf #(.DEPTH(PAYLOAD_MAX), .AW(AW)) u_buf (
    .clk(CLK_48MHZ),
    .we(accept),
    .waddr(count[AW-1:0]),
    .wdata(DATA_IN),
    .raddr(ptr[AW-1:0]),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: randomized and directed stimulus checked every cycle against a queue-based frame model.
module tb_packet_framer;
  localparam int MAX = 32;
  logic clk = 0, rst = 1, dv = 0, send = 0, txr = 0;
  logic [7:0] din = 0;
  logic dr, txv, txl, busy;
  logic [7:0] txb;
  int checks = 0, errors = 0;
  logic [7:0] pl[$];
  logic [8:0] txq[$], obs[$];
  logic [7:0] seqm = 0;
  bit armed = 0;

  always #10 clk = ~clk;

  packet_framer dut (
    .CLK_48MHZ(clk), .RESET(rst), .DATA_IN(din), .DATA_VALID(dv), .DATA_READY(dr),
    .SEND(send), .TX_BYTE(txb), .TX_VALID(txv), .TX_READY(txr), .TX_LAST(txl), .BUSY(busy)
  );

  function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
    logic [7:0] c = 0;
    foreach (msg[i]) for (int b = 7; b >= 0; b--) begin
      logic fb;
      fb = c[7] ^ msg[i][b];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pl.delete(); txq.delete(); seqm = 0; armed = 0;
  endtask

  task automatic check();
    cmp("data_ready", dr, armed && txq.size() == 0 && pl.size() < MAX);
    cmp("busy", busy, txq.size() != 0);
    cmp("tx_valid", txv, txq.size() != 0);
    if (txq.size() != 0) begin
      cmp("tx_byte", txb, txq[0][7:0]);
      cmp("tx_last", txl, txq.size() == 1);
    end else cmp("tx_last_idle", txl, 0);
    if (txv && txr) obs.push_back({txl, txb});
  endtask

  task automatic model_step();
    logic [7:0] f[$];
    bit collect;
    if (rst) begin
      model_clear();
      return;
    end
    collect = txq.size() == 0;
    if (collect && dv && armed && pl.size() < MAX) pl.push_back(din);
    if (!collect && txr) begin
      if (txq.size() == 1) seqm++;
      void'(txq.pop_front());
    end
    if (collect && ((send && pl.size() > 0) || pl.size() == MAX)) begin
      f = {8'(pl.size() + 2), seqm};
      foreach (pl[i]) f.push_back(pl[i]);
      foreach (f[i]) txq.push_back({1'b0, f[i]});
      txq.push_back({1'b1, crc_ref(f)});
      pl.delete();
    end
    armed = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain(input int max, input bit rnd);
    int n = 0;
    dv = 0; send = 0;
    while (txq.size() != 0 && n < max) begin
      txr = rnd ? 1'($urandom % 2) : 1'b1;
      cycle();
      n++;
    end
    if (txq.size() != 0) cmp("drain_timeout", 9'(txq.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1; model_clear();
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic frame_zero(input string tag);
    obs.delete();
    cycle();
    dv = 1; din = 8'h00; cycle();
    dv = 0; send = 1; txr = 1; cycle();
    drain(50, 0);
    cmp({tag, "_size"}, 9'(obs.size()), 4);
    if (obs.size() == 4) begin
      cmp({tag, "_len"}, obs[0], 9'h003);
      cmp({tag, "_seq"}, obs[1], 9'h000);
      cmp({tag, "_pl"}, obs[2], 9'h000);
      cmp({tag, "_crc"}, obs[3], 9'h1BD);
    end
  endtask

  initial begin
    int n;
    do_reset();
    frame_zero("first");
    obs.delete();
    txr = 1; dv = 1;
    for (int i = 0; i < MAX; i++) begin
      din = 8'($urandom); cycle();
    end
    cmp("auto_ready_low", dr, 0);
    for (int i = 0; i < 40 && txq.size() != 0; i++) cycle();
    dv = 0;
    cmp("auto_size", 9'(obs.size()), 35);
    if (obs.size() == 35) begin
      cmp("auto_len", obs[0], 9'h022);
      cmp("auto_last", 9'(obs[34][8]), 1);
    end
    send = 1; dv = 0;
    for (int i = 0; i < 3; i++) cycle();
    send = 0;
    cmp("empty_send_busy", busy, 0);
    cmp("empty_send_valid", txv, 0);
    obs.delete();
    dv = 1;
    for (int i = 0; i < 5; i++) begin
      din = 8'($urandom); send = i == 4; cycle();
    end
    drain(200, 1);
    cmp("stall_size", 9'(obs.size()), 8);
    if (obs.size() == 8) cmp("stall_len", obs[0], 9'h007);
    dv = 1; txr = 1;
    for (int i = 0; i < 6; i++) begin
      din = 8'($urandom); cycle();
    end
    dv = 0; send = 1; cycle();
    send = 0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1;
    #1;
    cmp("rst_tx_valid", txv, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_ready", dr, 0);
    cmp("rst_tx_byte", txb, 0);
    model_clear();
    cycle();
    rst = 0;
    frame_zero("after_rst");
    do_reset();
    cycle();
    for (int k = 0; k < 257; k++) begin
      obs.delete();
      n = 1 + $urandom % 3;
      dv = 1;
      for (int i = 0; i < n; i++) begin
        din = 8'($urandom); send = i == n - 1; cycle();
      end
      drain(100, 1);
      if (obs.size() > 1) cmp("seq_run", obs[1], {1'b0, 8'(k)});
      else cmp("seq_frame_size", 9'(obs.size()), 9'(n + 3));
    end
    for (int i = 0; i < 1500; i++) begin
      dv = 1'($urandom % 2); din = 8'($urandom);
      send = ($urandom % 8) == 0; txr = ($urandom % 3) != 0;
      cycle();
    end
    drain(200, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
